// File: rtl/seq_code_tx_if.sv
// seq_code_tx_if
//   Bundles the request/result and lock-side signals of the serial code
//   transmitter.
//   master : controlling logic / lock model side (drives start, code,
//            lock_in, alarm_in; observes seq_out, busy, done, ok)
//   slave  : the transmitter itself
//   Signals:
//     start    request strobe, sampled only while the transmitter is idle
//     code     parallel code word, latched when start is accepted
//     lock_in  lock_sys response from the lock
//     alarm_in alarm response from the lock
//     seq_out  serial bit to the lock's seq_in
//     busy     high whenever the transmitter is not idle
//     done     one-cycle completion pulse
//     ok       pass/fail result, valid with done and held until next start
interface seq_code_tx_if #(
  parameter int CODE_W = 4
);
  logic              start;
  logic [CODE_W-1:0] code;
  logic              lock_in;
  logic              alarm_in;
  logic              seq_out;
  logic              busy;
  logic              done;
  logic              ok;

  modport master (
    output start, code, lock_in, alarm_in,
    input  seq_out, busy, done, ok
  );

  modport slave (
    input  start, code, lock_in, alarm_in,
    output seq_out, busy, done, ok
  );
endinterface

// File: rtl/seq_code_tx.sv
// seq_code_tx
//   Serial code transmitter feeding a sequence-detecting lock. On an accepted
//   start it latches a code word and shifts it out MSB-first, one bit per
//   clock, then watches the lock's responses. A failed attempt (alarm or
//   response-window timeout) is retried after an idle gap, up to MAX_TRY
//   attempts in total. A single done pulse reports the pass/fail result.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     tx   seq_code_tx_if.slave (start/code in, lock_in/alarm_in in,
//          seq_out/busy/done/ok out, all outputs registered)
module seq_code_tx #(
  parameter int   CODE_W   = 4,
  parameter int   RESP_WIN = 3,
  parameter int   GAP      = 2,
  parameter int   MAX_TRY  = 3,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  seq_code_tx_if.slave  tx
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEND = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int BW = (CODE_W   > 1) ? $clog2(CODE_W)   : 1;
  localparam int WW = (RESP_WIN > 1) ? $clog2(RESP_WIN) : 1;
  localparam int GW = (GAP      > 1) ? $clog2(GAP)      : 1;
  localparam int TW = $clog2(MAX_TRY) + 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(CODE_W - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(RESP_WIN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRY - 1);

  logic [2:0]        state_q,     state_d;
  logic [CODE_W-1:0] code_r_q,    code_r_d;
  logic [BW-1:0]     bit_idx_q,   bit_idx_d;
  logic [WW-1:0]     win_cnt_q,   win_cnt_d;
  logic [GW-1:0]     gap_cnt_q,   gap_cnt_d;
  logic [TW-1:0]     try_cnt_q,   try_cnt_d;
  logic              ok_q,        ok_d;
  logic              seq_out_q,   seq_out_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              lock_last_q, lock_last_d;
  logic              alarm_last_q, alarm_last_d;

  logic last_bit;
  logic lock_hit;
  logic alarm_hit;

  // The lock is Mealy and may answer during the final bit. That answer is
  // captured here and judged together with the first WAIT cycle, so both
  // feed the same decision edge; at all other times these flops clear.
  assign last_bit     = (state_q == S_SEND) && (bit_idx_q == '0);
  assign lock_last_d  = last_bit & tx.lock_in;
  assign alarm_last_d = last_bit & tx.alarm_in;

  // Only meaningful in WAIT; the *_last_q terms are non-zero only in the
  // first WAIT cycle.
  assign lock_hit  = lock_last_q  | tx.lock_in;
  assign alarm_hit = alarm_last_q | tx.alarm_in;

  always_comb begin
    state_d   = state_q;
    code_r_d  = code_r_q;
    bit_idx_d = bit_idx_q;
    win_cnt_d = win_cnt_q;
    gap_cnt_d = gap_cnt_q;
    try_cnt_d = try_cnt_q;
    ok_d      = ok_q;

    case (state_q)
      S_IDLE: begin
        if (tx.start) begin
          code_r_d  = tx.code;
          try_cnt_d = '0;
          ok_d      = 1'b0;
          bit_idx_d = BIT_LAST;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        if (bit_idx_q == '0) begin
          win_cnt_d = '0;
          state_d   = S_WAIT;
        end else begin
          bit_idx_d = bit_idx_q - 1'b1;
        end
      end

      S_WAIT: begin
        if (lock_hit) begin
          // lock wins over a simultaneous alarm
          ok_d    = 1'b1;
          state_d = S_DONE;
        end else if (alarm_hit || (win_cnt_q == WIN_LAST)) begin
          if (try_cnt_q < TRY_LAST) begin
            try_cnt_d = try_cnt_q + 1'b1;
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            ok_d    = 1'b0;
            state_d = S_DONE;
          end
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          bit_idx_d = BIT_LAST;
          state_d   = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    seq_out_d = IDLE_BIT;
    if (state_d == S_SEND) begin
      seq_out_d = code_r_d[bit_idx_d];
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      code_r_q     <= '0;
      bit_idx_q    <= '0;
      win_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      try_cnt_q    <= '0;
      ok_q         <= 1'b0;
      seq_out_q    <= IDLE_BIT;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lock_last_q  <= 1'b0;
      alarm_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_r_q     <= code_r_d;
      bit_idx_q    <= bit_idx_d;
      win_cnt_q    <= win_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      try_cnt_q    <= try_cnt_d;
      ok_q         <= ok_d;
      seq_out_q    <= seq_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lock_last_q  <= lock_last_d;
      alarm_last_q <= alarm_last_d;
    end
  end

  assign tx.seq_out = seq_out_q;
  assign tx.busy    = busy_q;
  assign tx.done    = done_q;
  assign tx.ok      = ok_q;

endmodule

// File: tb/tb_seq_code_tx.sv
// tb_seq_code_tx
//   Directed bench for seq_code_tx with default parameters. A timeline model
//   derives, per frame, the expected seq_out/busy/done/ok for every cycle
//   relative to the accepting edge; one negedge process compares the DUT
//   against it. Literal expectations pin the model's done cycle and result.
module tb_seq_code_tx;
  localparam int W  = 4;
  localparam int R  = 3;
  localparam int G  = 2;
  localparam int MT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_code_tx_if #(.CODE_W(W)) bus ();

  seq_code_tx #(
    .CODE_W(W), .RESP_WIN(R), .GAP(G), .MAX_TRY(MT), .IDLE_BIT(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic exp_seq  [0:63];
  logic exp_busy [0:63];
  logic exp_done [0:63];
  logic exp_ok   [0:63];

  int   cur_r    = 0;
  logic checking = 1'b0;
  int   obs_done = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Timeline model. Attempt starting at relative cycle t: bits in t+1..t+W.
  // Responses in the last-bit cycle and the first WAIT cycle are judged at
  // the same edge (end of t+W+1); WAIT cycle j>0 is judged at end of t+W+1+j.
  // Lock beats alarm. A failure with tries left restarts after G idle cycles.
  task automatic model_build(input logic [W-1:0] c, input logic [63:0] lm,
                             input logic [63:0] am, output int dn, output logic res);
    int  t;
    int  att;
    int  dend;
    bit  fin;
    bit  l;
    bit  a;
    for (int i = 0; i < 64; i++) exp_seq[i] = 1'b1;
    t = 0; att = 0; fin = 0; dn = 0; res = 1'b0;
    while (!fin) begin
      for (int i = 0; i < W; i++) exp_seq[t + 1 + i] = c[W - 1 - i];
      for (int j = 0; j < R; j++) begin
        dend = t + W + 1 + j;
        l = lm[dend];
        a = am[dend];
        if (j == 0) begin
          l = l | lm[t + W];
          a = a | am[t + W];
        end
        if (l) begin
          res = 1'b1; dn = dend + 1; fin = 1; break;
        end else if (a || j == R - 1) begin
          att++;
          if (att == MT) begin
            res = 1'b0; dn = dend + 1; fin = 1;
          end else begin
            t = dend + G;
          end
          break;
        end
      end
    end
    for (int r = 0; r < 64; r++) begin
      exp_busy[r] = (r >= 1) && (r <= dn);
      exp_done[r] = (r == dn);
      exp_ok[r]   = (r >= dn) ? res : 1'b0;
    end
  endtask

  // single compare process
  always @(negedge clk) begin
    if (checking) begin
      chk($sformatf("seq_out r=%0d", cur_r), 32'(bus.seq_out), 32'(exp_seq[cur_r]));
      chk($sformatf("busy r=%0d",    cur_r), 32'(bus.busy),    32'(exp_busy[cur_r]));
      chk($sformatf("done r=%0d",    cur_r), 32'(bus.done),    32'(exp_done[cur_r]));
      chk($sformatf("ok r=%0d",      cur_r), 32'(bus.ok),      32'(exp_ok[cur_r]));
      if (bus.done === 1'b1) obs_done = cur_r;
    end
  end

  task automatic frame(input string nm, input logic [W-1:0] c, input logic [63:0] lm,
                       input logic [63:0] am, input bit hold, input bit chg,
                       input int lit_done, input logic lit_ok);
    int   dn;
    logic res;
    model_build(c, lm, am, dn, res);
    chk({nm, " model_done"}, 32'(dn), 32'(lit_done));
    chk({nm, " model_ok"},   32'(res), 32'(lit_ok));
    obs_done  = 0;
    bus.code  = c;
    bus.start = 1'b1;
    bus.lock_in  = 1'b0;
    bus.alarm_in = 1'b0;
    @(posedge clk);                       // accepting edge k
    for (int r = 1; r <= dn + 1; r++) begin
      #1;
      cur_r        = r;
      checking     = 1'b1;
      bus.lock_in  = lm[r];
      bus.alarm_in = am[r];
      if (r == 1) begin
        if (!hold) bus.start = 1'b0;
        if (chg)   bus.code  = ~c;
      end
      @(negedge clk);
      #1;
      if (r <= dn) @(posedge clk);
    end
    checking     = 1'b0;
    bus.lock_in  = 1'b0;
    bus.alarm_in = 1'b0;
    chk({nm, " dut_done_cycle"}, 32'(obs_done), 32'(lit_done));
    $display("frame %s code=%b done@k+%0d ok=%0d", nm, c, obs_done, bus.ok);
  endtask

  initial begin
    logic [63:0] lm;
    logic [63:0] am;
    int pulses;
    bus.start = 1'b0; bus.code = '0; bus.lock_in = 1'b0; bus.alarm_in = 1'b0;

    @(posedge clk); #2;
    chk("reset seq_out", 32'(bus.seq_out), 32'd1);
    chk("reset busy",    32'(bus.busy),    32'd0);
    chk("reset done",    32'(bus.done),    32'd0);
    chk("reset ok",      32'(bus.ok),      32'd0);
    @(negedge clk); rst = 1'b0;

    // pass on first try: lock in last-bit cycle
    lm = '0; am = '0; lm[4] = 1'b1;
    model_build(4'b0100, lm, am, pulses, exp_ok[0]);
    chk("model bits 0100", 32'({exp_seq[1], exp_seq[2], exp_seq[3], exp_seq[4]}), 32'h4);
    frame("pass1", 4'b0100, lm, am, 0, 0, 6, 1'b1);

    // alarm in WAIT cycle 1 of attempt 1, lock in WAIT cycle 1 of attempt 2
    lm = '0; am = '0; am[6] = 1'b1; lm[14] = 1'b1;
    frame("alarm_pass", 4'b1011, lm, am, 0, 0, 15, 1'b1);

    // no response at all: three timeouts
    lm = '0; am = '0;
    frame("total_fail", 4'b1001, lm, am, 0, 0, 26, 1'b0);

    // simultaneous lock and alarm in the last-bit cycle
    lm = '0; am = '0; lm[4] = 1'b1; am[4] = 1'b1;
    frame("simul", 4'b0110, lm, am, 0, 0, 6, 1'b1);

    // alarm in each last-bit cycle; locks during SEND and GAP are ignored
    lm = '0; am = '0; am[4] = 1'b1; am[11] = 1'b1; am[18] = 1'b1;
    lm[2] = 1'b1; lm[6] = 1'b1;
    frame("alarm_fail", 4'b1110, lm, am, 0, 0, 20, 1'b0);

    // start held high, code changed mid-frame, then back-to-back frame
    lm = '0; am = '0; lm[5] = 1'b1;
    frame("hold_chg", 4'b1100, lm, am, 1, 1, 6, 1'b1);
    lm = '0; am = '0; lm[4] = 1'b1;
    frame("back2back", 4'b0011, lm, am, 0, 0, 6, 1'b1);

    // reset during the second bit
    bus.code = 4'b0000; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst seq_out", 32'(bus.seq_out), 32'd0);
    chk("pre_rst busy",    32'(bus.busy),    32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst seq_out", 32'(bus.seq_out), 32'd1);
    chk("async_rst busy",    32'(bus.busy),    32'd0);
    chk("async_rst done",    32'(bus.done),    32'd0);
    chk("async_rst ok",      32'(bus.ok),      32'd0);
    @(posedge clk); @(negedge clk); rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    chk("no_done_after_rst", 32'(pulses), 32'd0);
    $display("frame rst_mid code=0000 aborted done_pulses=%0d", pulses);

    lm = '0; am = '0; lm[4] = 1'b1;
    frame("after_rst", 4'b1010, lm, am, 0, 0, 6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
